// File: rtl/kalman_scalar_core.sv
// kalman_scalar_core: N_CH scalar Kalman filters sharing one multiplier and divider.
// Optional KALMAN_SAT_EN: saturate xp, innovation, x and pp instead of wrapping.
module kalman_scalar_core #(
    parameter int W      = 16,
    parameter int FRAC   = 12,
    parameter int N_CH   = 2,
    parameter int Q_VAL  = 8,
    parameter int R_VAL  = 819,
    parameter int DT     = 41,
    parameter int P_INIT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_CH*W-1:0] z_meas,
    input  logic [N_CH*W-1:0] u_rate,
    output logic              busy,
    output logic              out_valid,
    output logic [N_CH*W-1:0] x_est,
    output logic [N_CH*W-1:0] p_est
);

    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW  = $clog2(FRAC + 1);
    localparam int WW  = 2 * W + 3;

    localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);
    localparam logic [CW-1:0]  LAST_IT = CW'(FRAC - 1);
    localparam logic [W:0]     ONE     = (W + 1)'(2 ** FRAC);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PRED, S_DIV, S_UPD, S_COV, S_DONE
    } state_t;

    state_t state;

    logic [CHW-1:0]       ch;
    logic [CW-1:0]        cnt;
    logic signed [W-1:0]  x_r [N_CH];
    logic signed [W-1:0]  p_r [N_CH];
    logic signed [W-1:0]  z_r [N_CH];
    logic signed [W-1:0]  u_r [N_CH];
    logic signed [W-1:0]  xp;
    logic signed [W-1:0]  pp;
    logic [W+1:0]         rem;
    logic [FRAC-1:0]      q;

    logic signed [W:0]     mul_a;
    logic signed [W:0]     mul_b;
    logic signed [2*W+1:0] prod;
    logic signed [2*W+1:0] prod_sh;
    logic signed [W:0]     innov_raw;
    logic signed [W:0]     innov;
    logic signed [W-1:0]   innov_f;
    logic signed [W-1:0]   xp_nxt;
    logic signed [W-1:0]   pp_fit;
    logic signed [W-1:0]   pp_nxt;
    logic signed [W-1:0]   x_nxt;
    logic signed [W-1:0]   p_fit;
    logic signed [W-1:0]   p_nxt;
    logic [W:0]            den;
    logic [W+1:0]          rem_sh;

    // Reduce a wide signed result to W bits: clip or wrap
    function automatic logic signed [W-1:0] fit(input logic signed [WW-1:0] v);
`ifdef KALMAN_SAT_EN
        if (v > WW'(2 ** (W - 1) - 1))
            fit = W'(2 ** (W - 1) - 1);
        else if (v < -WW'(2 ** (W - 1)))
            fit = W'(-(2 ** (W - 1)));
        else
            fit = v[W-1:0];
`else
        fit = v[W-1:0];
`endif
    endfunction

    // Shared multiplier operand select and per-state result arithmetic
    always_comb begin
        innov_raw = {z_r[ch][W-1], z_r[ch]} - {xp[W-1], xp};
        innov_f   = fit(WW'(innov_raw));
`ifdef KALMAN_SAT_EN
        innov     = {innov_f[W-1], innov_f};
`else
        innov     = innov_raw;
`endif
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            S_PRED: begin
                mul_a = {u_r[ch][W-1], u_r[ch]};
                mul_b = (W + 1)'(DT);
            end
            S_UPD: begin
                mul_a = $signed((W + 1)'(q));
                mul_b = innov;
            end
            S_COV: begin
                mul_a = $signed(ONE - (W + 1)'(q));
                mul_b = {pp[W-1], pp};
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        prod    = mul_a * mul_b;
        prod_sh = prod >>> FRAC;
        xp_nxt  = fit(WW'(x_r[ch]) + WW'(prod_sh));
        pp_fit  = fit(WW'(p_r[ch]) + WW'(Q_VAL));
        pp_nxt  = pp_fit[W-1] ? '0 : pp_fit;
        x_nxt   = fit(WW'(xp) + WW'(prod_sh));
        p_fit   = fit(WW'(prod_sh));
        p_nxt   = p_fit[W-1] ? '0 : p_fit;
        den     = {1'b0, pp} + (W + 1)'(R_VAL);
        rem_sh  = {rem[W:0], 1'b0};
    end

    // Sequencer: one channel at a time through predict/divide/update/cov
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            ch        <= '0;
            cnt       <= '0;
            xp        <= '0;
            pp        <= '0;
            rem       <= '0;
            q         <= '0;
            for (int c = 0; c < N_CH; c++) begin
                x_r[c] <= '0;
                p_r[c] <= W'(P_INIT);
                z_r[c] <= '0;
                u_r[c] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int c = 0; c < N_CH; c++) begin
                        z_r[c] <= z_meas[c*W +: W];
                        u_r[c] <= u_rate[c*W +: W];
                    end
                    ch    <= '0;
                    state <= S_PRED;
                end
                S_PRED: begin
                    xp    <= xp_nxt;
                    pp    <= pp_nxt;
                    rem   <= {2'b00, pp_nxt};
                    q     <= '0;
                    cnt   <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    if (rem_sh >= {1'b0, den}) begin
                        rem <= rem_sh - {1'b0, den};
                        q   <= {q[FRAC-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        q   <= {q[FRAC-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IT)
                        state <= S_UPD;
                end
                S_UPD: begin
                    x_r[ch] <= x_nxt;
                    state   <= S_COV;
                end
                S_COV: begin
                    p_r[ch] <= p_nxt;
                    if (ch < LAST_CH) begin
                        ch    <= ch + 1'b1;
                        state <= S_PRED;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign x_est[c*W +: W] = x_r[c];
        assign p_est[c*W +: W] = p_r[c];
    end

endmodule
